// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler fetch/branch sequencer: opcodes, state
// encoding and return-stack depth.
package nibbler_pkg;

  localparam logic [3:0] OP_JC   = 4'h0;
  localparam logic [3:0] OP_CALL = 4'h2;
  localparam logic [3:0] OP_RET  = 4'h3;
  localparam logic [3:0] OP_JNC  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JNZ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hE;

  localparam int unsigned STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    S_FETCH,
    S_OPERAND,
    S_BRANCH
  } seq_state_t;

  function automatic logic is_jump(input logic [3:0] op);
    return op inside {OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP};
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry
// and a pop when empty returns zero.
module ret_stack
  import nibbler_pkg::*;
#(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = STACK_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0] ptr_q, ptr_d, top_idx;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign top_idx = ptr_q - PW'(1);
  assign dout    = empty ? '0 : mem_q[top_idx];

  // DEPTH is a power of two, so the write pointer simply wraps; when full it
  // lands on the oldest entry, which is exactly the slot to overwrite.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Nibbler PC fetch/branch sequencer. Define PC_SEQ_STACK_EN to build the
// CALL/RET return stack; otherwise CALL/RET execute as ordinary opcodes.
module pc_sequencer
  import nibbler_pkg::*;
#(
  parameter int unsigned N = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [7:0]   instr,
  input  logic [N-1:0] pcAddress,
  input  logic         carry,
  input  logic         zero,
  output logic         notLoadPC,
  output logic         incPC,
  output logic [N-1:0] loadAddress,
  output logic [3:0]   opcode,
  output logic [3:0]   operand,
  output logic         exec,
  output logic         halted,
  output logic         stackErr
);

  seq_state_t   state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [3:0]   hi_q, hi_d;
  logic [7:0]   lo_q, lo_d;
  logic         taken;
  logic         stk_push, stk_pop;
  logic [N-1:0] stk_dout;
  logic [N-1:0] target;

  assign target = N'({hi_q, lo_q});

`ifdef PC_SEQ_STACK_EN
  localparam bit STACK_EN = 1'b1;

  logic stk_full, stk_empty;
  logic err_q, err_d;

  ret_stack #(
    .W     (N),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pcAddress),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb err_d = err_q | (stk_push & stk_full) | (stk_pop & stk_empty);

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign stackErr = err_q;
`else
  localparam bit STACK_EN = 1'b0;

  logic unused_stack;

  assign stk_dout     = '0;
  assign stackErr     = 1'b0;
  assign unused_stack = ^{stk_push, stk_pop, pcAddress};
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    taken       = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    notLoadPC   = 1'b1;
    incPC       = 1'b0;
    loadAddress = '0;
    opcode      = '0;
    operand     = '0;
    exec        = 1'b0;
    halted      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          opcode  = instr[7:4];
          operand = instr[3:0];
          if (!run) begin
            halted = 1'b1;
          end else begin
            incPC = 1'b1;
            op_d  = instr[7:4];
            hi_d  = instr[3:0];
            if (is_jump(instr[7:4]) || (STACK_EN && instr[7:4] == OP_CALL))
              state_d = S_OPERAND;
            else if (STACK_EN && instr[7:4] == OP_RET)
              state_d = S_BRANCH;
            else
              exec = 1'b1;
          end
        end
        S_OPERAND: begin
          incPC   = 1'b1;
          lo_d    = instr;
          state_d = S_BRANCH;
        end
        S_BRANCH: begin
          state_d = S_FETCH;
          case (op_q)
            OP_JC:   taken = carry;
            OP_JNC:  taken = ~carry;
            OP_JZ:   taken = zero;
            OP_JNZ:  taken = ~zero;
            OP_JMP:  taken = 1'b1;
            OP_CALL: begin
              taken    = STACK_EN;
              stk_push = STACK_EN;
            end
            OP_RET: begin
              taken   = STACK_EN;
              stk_pop = STACK_EN;
            end
            default: taken = 1'b0;
          endcase
          if (taken) begin
            notLoadPC   = 1'b0;
            loadAddress = (op_q == OP_RET) ? stk_dout : target;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural PC and program memory drive
// the sequencer; expected per-cycle outputs go through a scoreboard queue.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  instr;
  logic [11:0] pcAddress;
  logic        carry;
  logic        zero;
  logic        notLoadPC;
  logic        incPC;
  logic [11:0] loadAddress;
  logic [3:0]  opcode;
  logic [3:0]  operand;
  logic        exec;
  logic        halted;
  logic        stackErr;

  logic [7:0]  mem [4096];
  logic [11:0] pc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic        nl;
    logic        inc;
    logic [11:0] la;
    logic        ex;
    logic        hl;
    int          op;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(.N(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr       (instr),
    .pcAddress   (pcAddress),
    .carry       (carry),
    .zero        (zero),
    .notLoadPC   (notLoadPC),
    .incPC       (incPC),
    .loadAddress (loadAddress),
    .opcode      (opcode),
    .operand     (operand),
    .exec        (exec),
    .halted      (halted),
    .stackErr    (stackErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter as it sits next to the sequencer in the real machine.
  always @(posedge clk) begin
    if (reset)           pc <= '0;
    else if (!notLoadPC) pc <= loadAddress;
    else if (incPC)      pc <= pc + 12'd1;
  end

  assign pcAddress = pc;
  assign instr     = mem[pc];

  task automatic chk(input string tag, input string fld, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s.%s got=%0h want=%0h", tag, fld, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got=0 want=1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "notLoadPC",   {31'b0, notLoadPC}, {31'b0, e.nl});
    chk(e.tag, "incPC",       {31'b0, incPC},     {31'b0, e.inc});
    chk(e.tag, "loadAddress", {20'b0, loadAddress}, {20'b0, e.la});
    chk(e.tag, "exec",        {31'b0, exec},      {31'b0, e.ex});
    chk(e.tag, "halted",      {31'b0, halted},    {31'b0, e.hl});
    if (e.op >= 0) chk(e.tag, "opcode", {28'b0, opcode}, e.op);
  endtask

  // Inputs are already set; record what this cycle must show, sample it
  // mid-cycle, then move past the next rising edge.
  task automatic step(input string tag, input logic nl, input logic inc, input logic [11:0] la,
                      input logic ex, input logic hl, input int op);
    exp_t e;
    e.tag = tag; e.nl = nl; e.inc = inc; e.la = la; e.ex = ex; e.hl = hl; e.op = op;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("rst", 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, -1);
    reset = 1'b0;
  endtask

  task automatic do_jump(input string tag, input int op, input bit tk, input logic [11:0] tgt);
    step({tag, "_f"}, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, op);
    step({tag, "_o"}, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 0);
    step({tag, "_b"}, !tk, 1'b0, tk ? tgt : 12'h000, 1'b0, 1'b0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h1F;
    reset = 1'b1;
    run   = 1'b0;
    carry = 1'b0;
    zero  = 1'b0;
    @(posedge clk);
    #1;

    // Straight-line non-flow code, then halt at a fetch boundary
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h13;
    do_reset();
    run = 1'b1;
    step("nf0", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1);
    step("nf1", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1);
    step("nf2", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1);
    run = 1'b0;
    step("nf_hlt", 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1);
    chk("nf", "pc", {20'b0, pc}, 32'h003);

    // Taken JZ; zero only rises in the BRANCH cycle
    mem[0] = 8'h83; mem[1] = 8'h45; mem[12'h345] = 8'h17;
    do_reset();
    run = 1'b1; carry = 1'b1; zero = 1'b0;
    step("jz_f", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 8);
    step("jz_o", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 0);
    zero = 1'b1;
    step("jz_b", 1'b0, 1'b0, 12'h345, 1'b0, 1'b0, 0);
    zero = 1'b0;
    chk("jz", "pc", {20'b0, pc}, 32'h345);
    step("jz_t", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1);

    // Not-taken JNC, then taken JC and JNZ
    mem[0] = 8'h41; mem[1] = 8'h00; mem[2] = 8'h15;
    mem[3] = 8'h05; mem[4] = 8'h67;
    mem[12'h567] = 8'hC1; mem[12'h568] = 8'h23; mem[12'h123] = 8'h1B;
    do_reset();
    carry = 1'b1; zero = 1'b1;
    do_jump("jnc", 4, 1'b0, 12'h000);
    chk("jnc", "pc", {20'b0, pc}, 32'h002);
    step("jnc_nx", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1);
    do_jump("jc", 0, 1'b1, 12'h567);
    zero = 1'b0;
    do_jump("jnz", 12, 1'b1, 12'h123);
    chk("jnz", "pc", {20'b0, pc}, 32'h123);
    carry = 1'b0;

    // run drops during OPERAND of a JMP: jump completes, then halt, resume
    mem[0] = 8'hE2; mem[1] = 8'h34; mem[12'h234] = 8'h19;
    do_reset();
    run = 1'b1;
    step("hj_f", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 14);
    run = 1'b0;
    step("hj_o", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 0);
    step("hj_b", 1'b0, 1'b0, 12'h234, 1'b0, 1'b0, 0);
    step("hj_h1", 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1);
    step("hj_h2", 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1);
    chk("hj", "pc", {20'b0, pc}, 32'h234);
    run = 1'b1;
    step("hj_run", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1);

    // Reset in the OPERAND cycle abandons the jump
    do_reset();
    step("mr_f", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 14);
    reset = 1'b1;
    step("mr_rst", 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, -1);
    reset = 1'b0;
    chk("mr", "pc", {20'b0, pc}, 32'h000);
    step("mr_fetch", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 14);
    chk("mr", "stackErr", {31'b0, stackErr}, 32'h0);

`ifdef PC_SEQ_STACK_EN
    mem[0] = 8'hE0; mem[1] = 8'h10;
    mem[12'h010] = 8'h21; mem[12'h011] = 8'h00; mem[12'h100] = 8'h30;
    mem[12'h012] = 8'h20; mem[12'h013] = 8'h20;
    mem[12'h020] = 8'h20; mem[12'h021] = 8'h30;
    mem[12'h030] = 8'h20; mem[12'h031] = 8'h40;
    mem[12'h040] = 8'h20; mem[12'h041] = 8'h50;
    mem[12'h050] = 8'h20; mem[12'h051] = 8'h60;
    mem[12'h060] = 8'h30;
    do_reset();
    do_jump("s_jmp", 14, 1'b1, 12'h010);
    do_jump("s_call", 2, 1'b1, 12'h100);
    step("s_ret_f", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 3);
    step("s_ret_b", 1'b0, 1'b0, 12'h012, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      do_jump("s_nest", 2, 1'b1, 12'h020 + 12'(i * 16));
      if (i == 3) chk("s_nest4", "stackErr", {31'b0, stackErr}, 32'h0);
    end
    chk("s_nest5", "stackErr", {31'b0, stackErr}, 32'h1);
    step("s_ret2_f", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 3);
    step("s_ret2_b", 1'b0, 1'b0, 12'h052, 1'b0, 1'b0, 0);

    mem[0] = 8'h30;
    do_reset();
    chk("s_rst", "stackErr", {31'b0, stackErr}, 32'h0);
    step("s_er_f", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 3);
    step("s_er_b", 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 0);
    chk("s_er", "stackErr", {31'b0, stackErr}, 32'h1);
    chk("s_er", "pc", {20'b0, pc}, 32'h000);
`else
    mem[0] = 8'h21; mem[1] = 8'h1F;
    do_reset();
    step("call_nf", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 2);
    step("call_nf2", 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1);
    chk("call_nf", "stackErr", {31'b0, stackErr}, 32'h0);
`endif

    chk("sb", "leftover", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/branch sequencer for the Nibbler program counter. Each cycle it decides whether the PC increments, loads a jump target, or holds. It drives the PC's `notLoadPC`, `incPC` and `loadAddress` inputs from the instruction byte on the program-memory bus and the ALU flags. It also hands every non-flow-control instruction to the datapath as a one-cycle execute strobe.

## Interface
- `N`, 12: program address width; matches the PC.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: 1 allows fetch; 0 holds at the next fetch boundary.
- `instr` in 8: program-memory byte at the current PC; combinational memory.
- `pcAddress` in N: current PC value; this is the return address source.
- `carry` in 1: ALU carry flag.
- `zero` in 1: ALU zero flag.
- `notLoadPC` out 1: active-low PC load.
- `incPC` out 1: PC increment.
- `loadAddress` out N: jump target, `{hiNibble, loByte}`.
- `opcode` out 4: `instr[7:4]` in FETCH; 0 otherwise.
- `operand` out 4: `instr[3:0]` in FETCH; 0 otherwise.
- `exec` out 1: execute strobe for a non-flow opcode.
- `halted` out 1: in FETCH with `run`=0.
- `stackErr` out 1: sticky return-stack fault.

## Operation
- **Flow opcodes:**
  - `JC`=4'h0: jump if `carry`.
  - `JNC`=4'h4: jump if not `carry`.
  - `JZ`=4'h8: jump if `zero`.
  - `JNZ`=4'hC: jump if not `zero`.
  - `JMP`=4'hE: unconditional jump.
  - `CALL`=4'h2 and `RET`=4'h3: flow opcodes only when the stack is enabled (see Configuration).
- **Other opcodes:** single-byte and non-flow.
- **Jump encoding:** two bytes.
  - Byte 0 is `{op, hiNibble}`.
  - Byte 1 is `loByte`.
  - Target is `{hiNibble, loByte}`.
- **States:** FETCH, OPERAND, BRANCH.
- **FETCH, `run`=0:**
  - `incPC`=0, `exec`=0, `halted`=1.
  - Stay in FETCH.
- **FETCH, `run`=1:**
  - `incPC`=1.
  - Latch `instr[7:4]` as the pending opcode and `instr[3:0]` as hiNibble.
  - Non-flow opcode: `exec`=1, stay in FETCH.
  - Jump or `CALL`: go to OPERAND.
  - `RET`: go to BRANCH.
- **OPERAND:**
  - `incPC`=1.
  - Latch `instr` as loByte.
  - Go to BRANCH.
- **BRANCH:**
  - `incPC`=0.
  - Evaluate the condition on `carry`/`zero` sampled this cycle.
  - Taken: `notLoadPC`=0 and `loadAddress`=target.
  - Not taken: `notLoadPC`=1; the PC already points past the operand.
  - Always go to FETCH.
- **Output defaults:**
  - `notLoadPC` is 0 only in a taken BRANCH.
  - `loadAddress` is 0 whenever `notLoadPC`=1.
- **`run` sampling:** sampled only in FETCH. A flow instruction in progress always completes.
- **Reset:**
  - State goes to FETCH; pending registers and stack clear; `stackErr` clears.
  - While `reset`=1 the outputs are forced: `notLoadPC`=1, `incPC`=0, `exec`=0, `halted`=0, `loadAddress`=0.
  - Reset mid-jump abandons the jump with no load.

## Timing
- **Cycles per instruction:** non-flow 1; jump or `CALL` 3; `RET` 2.
- **Output timing:** all outputs are combinational from registered state plus `instr`, `run`, `carry`, `zero`. The PC and datapath act on the same rising edge.
- **Flags:** sampled in the BRANCH cycle only. The datapath must not change flags while `exec`=0.
- **Target address:** computed in N bits. Wrap past `N'hFFF` follows the PC's own increment wrap; the sequencer adds nothing.

## Configuration
- **Macro:** `PC_SEQ_STACK_EN`.
- **Defined:**
  - 4-entry return stack.
  - `CALL` in BRANCH pushes `pcAddress` and always loads the target.
  - `RET` in BRANCH pops and loads the popped address.
  - Push when full overwrites the oldest entry and sets `stackErr`.
  - Pop when empty loads 0 and sets `stackErr`.
  - `stackErr` clears only on `reset`.
- **Undefined:**
  - `CALL` and `RET` are ordinary non-flow opcodes (`exec`=1).
  - `stackErr` is tied to 0.
  - No stack storage is built.

## Structure
- **Package `nibbler_pkg`:**
  - Opcode constants.
  - State enum `seq_state_t`.
  - `STACK_DEPTH`=4.
- **Sub-module `ret_stack`:**
  - Ports: push, pop, data in/out, full, empty.
  - Instantiated only under `PC_SEQ_STACK_EN`.

## Test plan
- **Non-flow run:** reset, `run`=1, memory holds 3 bytes of opcode 4'h1 → `exec` high 3 consecutive cycles, `incPC`=1 each cycle, `notLoadPC`=1 throughout.
- **Taken JZ:** `JZ` bytes 8'h83, 8'h45 at 0x000 with `zero`=1 in BRANCH → cycle 3 has `notLoadPC`=0 and `loadAddress`=12'h345; next FETCH at 0x345.
- **Not-taken JNC:** `JNC` bytes 8'h41, 8'h00 with `carry`=1 → no load; next fetch at 0x002.
- **Halt:**
  - `run`=0 asserted during OPERAND of a `JMP` → the jump completes, then `halted`=1, `incPC`=0.
  - `run`=1 again → fetch resumes at the target.
- **Mid-jump reset:** `reset` pulsed in the OPERAND cycle → the next cycle is FETCH with no load; `stackErr`=0.
- **Stack (`PC_SEQ_STACK_EN`):**
  - `CALL` 12'h100 at 0x010 → load 0x100.
  - `RET` → load 0x012.
  - Five nested `CALL`s → `stackErr`=1.
  - `RET` on an empty stack → load 0x000.
